mips_cpu_bus_arbiter: RTL and testbench
=======================================

Name: mips_cpu_bus_arbiter

Overview:
- Two-master, one-slave arbiter that shares the single Avalon-style bus memory between the CPU instruction-fetch port and the CPU data port.
- Sits between the CPU core and the bus memory (read/write/byteenable/addr/writedata in; waitrequest/readdata out).
- Round-robin grant, one outstanding transaction at a time.
- Watchdog aborts transfers stalled by the slave and flags a sticky error.

Parameters:
- ADDR_W, 32, address width on both master ports and the slave port.
- TIMEOUT, 1024, max consecutive cycles a granted transfer may see mem_waitrequest=1 before abort (>=2).
- CNT_W, 11, watchdog counter width; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  synchronous, active-high
- i_read  in  1  instruction fetch request (read-only port)
- i_addr  in  ADDR_W  fetch address
- i_waitrequest  out  1  stall to fetch master
- i_readdata  out  32  fetch data
- d_read  in  1  data read request
- d_write  in  1  data write request
- d_addr  in  ADDR_W  data address
- d_byteenable  in  4  data byte enables
- d_writedata  in  32  store data
- d_waitrequest  out  1  stall to data master
- d_readdata  out  32  load data
- mem_read  out  1  slave read strobe
- mem_write  out  1  slave write strobe
- mem_addr  out  ADDR_W  slave address
- mem_byteenable  out  4  slave byte enables
- mem_writedata  out  32  slave write data
- mem_waitrequest  in  1  slave stall
- mem_readdata  in  32  slave read data
- timeout_err  out  1  sticky watchdog error flag

Behaviour:
- States: IDLE, GRANT_I, GRANT_D (registered). last_grant register: 0=I, 1=D.
- Reset (clk edge with reset=1):
  - state=IDLE, last_grant=I (so D wins first tie), watchdog=0, timeout_err=0.
  - While reset=1: mem_read=mem_write=0, i_waitrequest=d_waitrequest=1.
  - A transfer in flight when reset arrives is dropped with no completion.
- Request definitions: a request is i_read for I, and (d_read|d_write) for D.
- IDLE:
  - Slave strobes are 0; both master waitrequests are 1.
  - Next state on requests:
    - only I requests → GRANT_I
    - only D requests → GRANT_D
    - both request → grant the master that is not last_grant
    - none → stay IDLE
  - last_grant is updated on grant.
- GRANT_x, slave port muxing:
  - mem_* strobes, address, byteenable and writedata are driven combinationally from master x.
  - Fetch grant: mem_write=0, mem_byteenable=4'b1111, mem_writedata=0.
- GRANT_x, waitrequests: the granted master's waitrequest = mem_waitrequest; the other master's waitrequest = 1.
- GRANT_x, completion:
  - A transfer completes in the cycle where the slave strobe=1 and mem_waitrequest=0.
  - Next state is IDLE; watchdog clears.
- Latency:
  - Request seen in IDLE at cycle N; strobe on slave at N+1; earliest completion at N+1; back in IDLE at N+2.
  - Minimum 2 cycles per transfer; back-to-back requests from the same master always see one IDLE cycle.
- Read data:
  - mem_readdata is broadcast to i_readdata and d_readdata unmodified.
  - It is valid only to the granted master in its completion cycle.
  - No byte-lane shifting or sign extension; that stays in the CPU.
- Master drops its request while granted (protocol violation):
  - Strobes fall to 0 with the request.
  - Next state is IDLE; no error.
- d_read and d_write both 1:
  - Both strobes are forwarded unchanged (the slave ignores that combination).
  - The transfer completes only on mem_waitrequest=0.
- Watchdog:
  - Increments each GRANT cycle with mem_waitrequest=1, saturating.
  - When it reaches TIMEOUT: next state IDLE, timeout_err←1, and the granted master's waitrequest stays 1.
  - The master retries or is reset; timeout_err clears only on reset.
- Simultaneous reset and completion: reset wins.

Test Plan:
- Reset then idle 5 cycles, no requests → mem_read=mem_write=0, both waitrequests=1, timeout_err=0.
- i_read=1, i_addr=0x00000010, slave waitrequest=0, readdata=0x2402000F:
  - mem_read=1 at N+1 with mem_byteenable=1111, i_waitrequest=0 and i_readdata=0x2402000F at N+1.
  - IDLE at N+2.
- Both masters request from reset:
  - D (d_write, addr 0x20, be=0011, data 0xBEEF) granted first.
  - Then I granted next; alternation continues I/D/I for 6 transfers held continuously.
- D read with mem_waitrequest=1 for 3 cycles → d_waitrequest=1 for those cycles, i_waitrequest=1 throughout, completion on the 4th grant cycle.
- TIMEOUT=4, mem_waitrequest stuck 1 on I grant → IDLE after 4 stalled cycles, timeout_err=1 sticky, pending D then granted.
- reset asserted mid GRANT_D stall → next cycle IDLE, strobes 0, after release a fresh I request is granted normally.

Source files
------------

// File: rtl/mips_cpu_bus_arbiter.sv
// Round-robin arbiter sharing one Avalon-style memory between the CPU fetch and data ports.
// One outstanding transfer at a time; a watchdog aborts slave stalls and raises a sticky error.
module mips_cpu_bus_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 1024,
  parameter int CNT_W   = 11
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_waitrequest,
  output logic [31:0]       i_readdata,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [3:0]        d_byteenable,
  input  logic [31:0]       d_writedata,
  output logic              d_waitrequest,
  output logic [31:0]       d_readdata,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_byteenable,
  output logic [31:0]       mem_writedata,
  input  logic              mem_waitrequest,
  input  logic [31:0]       mem_readdata,
  output logic              timeout_err
);

  typedef enum logic [1:0] {IDLE, GRANT_I, GRANT_D} state_e;

  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

  state_e           state_q;
  logic             last_grant_q;  // 0 = fetch port, 1 = data port
  logic [CNT_W-1:0] wdog_q;
  logic [CNT_W-1:0] wdog_d;
  logic             timeout_err_q;

  logic i_req, d_req, gnt_req, done, stall, expired;

  assign i_req   = i_read;
  assign d_req   = d_read | d_write;
  assign gnt_req = (state_q == GRANT_I) ? i_req :
                   (state_q == GRANT_D) ? d_req : 1'b0;
  assign done    = gnt_req & ~mem_waitrequest;
  assign stall   = gnt_req &  mem_waitrequest;
  assign wdog_d  = (wdog_q == TIMEOUT_C) ? wdog_q : wdog_q + CNT_W'(1);
  assign expired = stall & (wdog_d == TIMEOUT_C);

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      last_grant_q  <= 1'b0;
      wdog_q        <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          wdog_q <= '0;
          if (i_req && d_req) begin
            if (last_grant_q) begin
              state_q      <= GRANT_I;
              last_grant_q <= 1'b0;
            end else begin
              state_q      <= GRANT_D;
              last_grant_q <= 1'b1;
            end
          end else if (i_req) begin
            state_q      <= GRANT_I;
            last_grant_q <= 1'b0;
          end else if (d_req) begin
            state_q      <= GRANT_D;
            last_grant_q <= 1'b1;
          end
        end
        GRANT_I, GRANT_D: begin
          // A dropped request ends the grant quietly; only a stall timeout flags an error.
          if (!gnt_req || done) begin
            state_q <= IDLE;
            wdog_q  <= '0;
          end else if (expired) begin
            state_q       <= IDLE;
            wdog_q        <= '0;
            timeout_err_q <= 1'b1;
          end else begin
            wdog_q <= wdog_d;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // NOTE: every output gets a default before the case so no latch is inferred.
  always_comb begin
    mem_read       = 1'b0;
    mem_write      = 1'b0;
    mem_addr       = '0;
    mem_byteenable = 4'b0000;
    mem_writedata  = 32'h0;
    i_waitrequest  = 1'b1;
    d_waitrequest  = 1'b1;
    if (!reset) begin
      case (state_q)
        GRANT_I: begin
          mem_read       = i_read;
          mem_addr       = i_addr;
          mem_byteenable = 4'b1111;
          i_waitrequest  = mem_waitrequest;
        end
        GRANT_D: begin
          mem_read       = d_read;
          mem_write      = d_write;
          mem_addr       = d_addr;
          mem_byteenable = d_byteenable;
          mem_writedata  = d_writedata;
          d_waitrequest  = mem_waitrequest;
        end
        default: ;
      endcase
    end
  end

  assign i_readdata  = mem_readdata;
  assign d_readdata  = mem_readdata;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_mips_cpu_bus_arbiter.sv
// Self-checking bench for mips_cpu_bus_arbiter: directed cycle checks plus a
// scoreboard of expected slave-side transfers compared as each one completes.
module tb_mips_cpu_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_read;
  logic [31:0] i_addr;
  logic        i_waitrequest;
  logic [31:0] i_readdata;
  logic        d_read, d_write;
  logic [31:0] d_addr;
  logic [3:0]  d_byteenable;
  logic [31:0] d_writedata;
  logic        d_waitrequest;
  logic [31:0] d_readdata;
  logic        mem_read, mem_write;
  logic [31:0] mem_addr;
  logic [3:0]  mem_byteenable;
  logic [31:0] mem_writedata;
  logic        mem_waitrequest;
  logic [31:0] mem_readdata;
  logic        timeout_err;

  typedef struct packed {
    logic        is_d;
    logic [31:0] addr;
    logic        wr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } xfer_t;

  xfer_t sb_q[$];
  int    n_tests = 0;
  int    n_fail  = 0;

  mips_cpu_bus_arbiter #(.ADDR_W(32), .TIMEOUT(4), .CNT_W(3)) dut (
    .clk             (clk),
    .reset           (reset),
    .i_read          (i_read),
    .i_addr          (i_addr),
    .i_waitrequest   (i_waitrequest),
    .i_readdata      (i_readdata),
    .d_read          (d_read),
    .d_write         (d_write),
    .d_addr          (d_addr),
    .d_byteenable    (d_byteenable),
    .d_writedata     (d_writedata),
    .d_waitrequest   (d_waitrequest),
    .d_readdata      (d_readdata),
    .mem_read        (mem_read),
    .mem_write       (mem_write),
    .mem_addr        (mem_addr),
    .mem_byteenable  (mem_byteenable),
    .mem_writedata   (mem_writedata),
    .mem_waitrequest (mem_waitrequest),
    .mem_readdata    (mem_readdata),
    .timeout_err     (timeout_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  function automatic xfer_t mk(input logic is_d, input logic [31:0] addr, input logic wr,
                               input logic [3:0] be, input logic [31:0] wdata,
                               input logic [31:0] rdata);
    xfer_t x;
    x.is_d  = is_d;
    x.addr  = addr;
    x.wr    = wr;
    x.be    = be;
    x.wdata = wdata;
    x.rdata = rdata;
    return x;
  endfunction

  // Completion monitor: each slave handshake must match the oldest expected transfer.
  always @(negedge clk) begin
    if ((mem_read || mem_write) && !mem_waitrequest) begin
      xfer_t obs;
      obs.is_d  = (i_waitrequest == 1'b1) && (d_waitrequest == 1'b0);
      obs.addr  = mem_addr;
      obs.wr    = mem_write;
      obs.be    = mem_byteenable;
      obs.wdata = mem_writedata;
      obs.rdata = mem_write ? 32'h0 : (obs.is_d ? d_readdata : i_readdata);
      check("one_grant", 128'(i_waitrequest ^ d_waitrequest), 128'(1));
      if (sb_q.size() == 0) begin
        check("sb_unexpected", 128'(obs), 128'(0));
      end else begin
        check("sb_xfer", 128'(obs), 128'(sb_q.pop_front()));
      end
    end
  end

  initial begin
    reset = 1'b1; i_read = 1'b0; i_addr = '0;
    d_read = 1'b0; d_write = 1'b0; d_addr = '0; d_byteenable = '0; d_writedata = '0;
    mem_waitrequest = 1'b0; mem_readdata = '0;

    // Reset, then idle
    repeat (2) tick();
    sample();
    check("rst_mem_read", 128'(mem_read), 128'(0));
    check("rst_i_wait", 128'(i_waitrequest), 128'(1));
    check("rst_d_wait", 128'(d_waitrequest), 128'(1));
    reset = 1'b0;
    repeat (5) tick();
    sample();
    check("idle_strobes", 128'({mem_read, mem_write}), 128'(0));
    check("idle_waits", 128'({i_waitrequest, d_waitrequest}), 128'(2'b11));
    check("idle_err", 128'(timeout_err), 128'(0));

    // Single fetch, zero-wait slave
    tick();
    i_read = 1'b1; i_addr = 32'h10; mem_waitrequest = 1'b0; mem_readdata = 32'h2402000F;
    sample();
    check("fetch_n_idle", 128'(mem_read), 128'(0));
    sb_q.push_back(mk(1'b0, 32'h10, 1'b0, 4'hF, 32'h0, 32'h2402000F));
    tick();
    sample();
    check("fetch_n1_read", 128'(mem_read), 128'(1));
    check("fetch_n1_be", 128'(mem_byteenable), 128'(4'hF));
    check("fetch_n1_wait", 128'(i_waitrequest), 128'(0));
    check("fetch_n1_data", 128'(i_readdata), 128'(32'h2402000F));
    tick();
    i_read = 1'b0;
    sample();
    check("fetch_n2_idle", 128'({mem_read, i_waitrequest}), 128'(2'b01));

    // Both masters held from reset: D first, then strict alternation
    reset = 1'b1;
    tick();
    reset = 1'b0;
    d_write = 1'b1; d_addr = 32'h20; d_byteenable = 4'b0011; d_writedata = 32'hBEEF;
    i_read = 1'b1; i_addr = 32'h40; mem_readdata = 32'h0000ABCD;
    for (int k = 0; k < 3; k++) begin
      sb_q.push_back(mk(1'b1, 32'h20, 1'b1, 4'b0011, 32'hBEEF, 32'h0));
      sb_q.push_back(mk(1'b0, 32'h40, 1'b0, 4'hF, 32'h0, 32'h0000ABCD));
    end
    sample();
    check("rr_c0_idle", 128'({mem_read, mem_write}), 128'(0));
    tick();
    sample();
    check("rr_first_d", 128'({i_waitrequest, d_waitrequest}), 128'(2'b10));
    repeat (11) tick();
    d_write = 1'b0; i_read = 1'b0; d_writedata = '0; d_byteenable = 4'hF;
    sample();
    check("rr_drained", 128'(sb_q.size()), 128'(0));

    // Data read stalled three cycles while a fetch waits
    tick();
    mem_waitrequest = 1'b1; mem_readdata = 32'h13579BDF;
    d_read = 1'b1; d_addr = 32'h80;
    i_read = 1'b1; i_addr = 32'h44;
    sb_q.push_back(mk(1'b1, 32'h80, 1'b0, 4'hF, 32'h0, 32'h13579BDF));
    sb_q.push_back(mk(1'b0, 32'h44, 1'b0, 4'hF, 32'h0, 32'h13579BDF));
    for (int k = 0; k < 3; k++) begin
      tick();
      sample();
      check("stall_waits", 128'({d_waitrequest, i_waitrequest, mem_read}), 128'(3'b111));
    end
    tick();
    mem_waitrequest = 1'b0;
    sample();
    check("stall_done", 128'({d_waitrequest, i_waitrequest}), 128'(2'b01));
    tick();
    d_read = 1'b0;
    sample();
    check("stall_idle_i_wait", 128'(i_waitrequest), 128'(1));
    tick();
    sample();
    check("stall_then_i", 128'(i_waitrequest), 128'(0));
    tick();
    i_read = 1'b0;

    // Watchdog abort on a stuck fetch, pending data request served afterwards
    tick();
    mem_waitrequest = 1'b1; i_read = 1'b1; i_addr = 32'h100;
    sample();
    check("to_c0_idle", 128'(mem_read), 128'(0));
    tick();
    d_read = 1'b1; d_addr = 32'h200;
    sample();
    check("to_c1", 128'({i_waitrequest, d_waitrequest, mem_read}), 128'(3'b111));
    repeat (3) tick();
    sample();
    check("to_c4_err_low", 128'(timeout_err), 128'(0));
    check("to_c4_stall", 128'({mem_read, i_waitrequest}), 128'(2'b11));
    tick();
    mem_waitrequest = 1'b0; i_read = 1'b0; mem_readdata = 32'h0BADF00D;
    sb_q.push_back(mk(1'b1, 32'h200, 1'b0, 4'hF, 32'h0, 32'h0BADF00D));
    sample();
    check("to_idle", 128'({mem_read, i_waitrequest}), 128'(2'b01));
    check("to_err_set", 128'(timeout_err), 128'(1));
    tick();
    sample();
    check("to_d_grant", 128'({d_waitrequest, mem_read, mem_addr}), {95'h0, 1'b0, 1'b1, 32'h200});
    tick();
    d_read = 1'b0;
    sample();
    check("to_err_sticky", 128'(timeout_err), 128'(1));

    // Reset during a stalled data grant, then a clean fetch
    tick();
    mem_waitrequest = 1'b1; d_read = 1'b1; d_addr = 32'h300;
    tick();
    sample();
    check("rg_stall", 128'({d_waitrequest, mem_read}), 128'(2'b11));
    tick();
    reset = 1'b1;
    sample();
    check("rg_gated", 128'({mem_read, d_waitrequest, i_waitrequest}), 128'(3'b011));
    tick();
    reset = 1'b0; d_read = 1'b0;
    i_read = 1'b1; i_addr = 32'h400; mem_waitrequest = 1'b0; mem_readdata = 32'h0000CAFE;
    sb_q.push_back(mk(1'b0, 32'h400, 1'b0, 4'hF, 32'h0, 32'h0000CAFE));
    sample();
    check("rg_idle", 128'({mem_read, mem_write}), 128'(0));
    check("rg_err_clr", 128'(timeout_err), 128'(0));
    tick();
    sample();
    check("rg_fetch", 128'({i_waitrequest, mem_read}), 128'(2'b01));
    tick();
    i_read = 1'b0;
    tick();
    sample();
    check("sb_final_empty", 128'(sb_q.size()), 128'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
